// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the three-way memory port arbiter: FSM encoding,
// mux select codes and requester count.
package mem_port_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam logic [1:0] SEL_REQ0 = 2'b00;
  localparam logic [1:0] SEL_REQ1 = 2'b01;
  localparam logic [1:0] SEL_REQ2 = 2'b10;

  localparam int NUM_REQ      = 3;
  localparam int MAX_WAIT_DEF = 15;

endpackage

// File: rtl/mem_port_arbiter_mux3.sv
// Generic 3:1 word mux shared by the address and write-data paths.
// The unused select code 2'b11 yields zero.
module mem_port_arbiter_mux3
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            sel,
  input  logic [DATA_WIDTH-1:0] d0,
  input  logic [DATA_WIDTH-1:0] d1,
  input  logic [DATA_WIDTH-1:0] d2,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (sel)
      SEL_REQ0: y = d0;
      SEL_REQ1: y = d1;
      SEL_REQ2: y = d2;
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single memory port for fetch/load/store requesters.
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = MAX_WAIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we_in,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] addr2,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [DATA_WIDTH-1:0] wdata2,
  output logic [NUM_REQ-1:0]    grant,
  output logic [1:0]            sel,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  output logic [NUM_REQ-1:0]    done,
  output logic                  timeout_err
);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         last_q, last_d;
  logic               mem_req_q, mem_req_d;
  logic [1:0]         win;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tmo_q, tmo_d;
`else
  logic               unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
`endif

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Search order last+1, last+2, last; only meaningful when req != 0.
  function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                         input logic [1:0] last);
    logic [1:0] c1, c2;
    c1 = rr_next(last);
    c2 = rr_next(c1);
    if (r[c1])      return c1;
    else if (r[c2]) return c2;
    else            return last;
  endfunction

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    mem_req_d = mem_req_q;
    last_d    = last_q;
    done_d    = '0;
    win       = rr_pick(req, last_q);
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d   = 3'b001 << win;
          sel_d     = win;
          mem_req_d = 1'b1;
          state_d   = BUSY;
`ifdef ARB_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      BUSY: begin
        // sel survives into IDLE so the muxes keep pointing at the last owner.
        if (mem_ack) begin
          done_d    = grant_q;
          grant_d   = '0;
          mem_req_d = 1'b0;
          last_d    = sel_q;
          state_d   = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(MAX_WAIT)) begin
          done_d    = grant_q;
          tmo_d     = 1'b1;
          grant_d   = '0;
          mem_req_d = 1'b0;
          last_d    = sel_q;
          state_d   = IDLE;
        end else begin
          cnt_d     = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= SEL_REQ0;
      mem_req_q <= 1'b0;
      done_q    <= '0;
      last_q    <= 2'd2;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      tmo_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      mem_req_q <= mem_req_d;
      done_q    <= done_d;
      last_q    <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign mem_req = mem_req_q;
  assign done    = done_q;

`ifdef ARB_TIMEOUT_EN
  assign timeout_err = tmo_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    mem_we = 1'b0;
    case (sel_q)
      SEL_REQ0: mem_we = we_in[0];
      SEL_REQ1: mem_we = we_in[1];
      SEL_REQ2: mem_we = we_in[2];
      default:  mem_we = 1'b0;
    endcase
  end

  mem_port_arbiter_mux3 #(.DATA_WIDTH(DATA_WIDTH)) u_addr_mux (
    .sel (sel_q),
    .d0  (addr0),
    .d1  (addr1),
    .d2  (addr2),
    .y   (mem_addr)
  );

  mem_port_arbiter_mux3 #(.DATA_WIDTH(DATA_WIDTH)) u_wdata_mux (
    .sel (sel_q),
    .d0  (wdata0),
    .d1  (wdata1),
    .d2  (wdata2),
    .y   (mem_wdata)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; inputs change and outputs are sampled
// on the falling edge. Timeout checks depend on ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    req, we_in, grant, done;
  logic [DW-1:0] addr0, addr1, addr2, wdata0, wdata1, wdata2;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic [1:0]    sel;
  logic          mem_req, mem_we, mem_ack, timeout_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(DW), .MAX_WAIT(15)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .we_in       (we_in),
    .addr0       (addr0),
    .addr1       (addr1),
    .addr2       (addr2),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .wdata2      (wdata2),
    .grant       (grant),
    .sel         (sel),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .done        (done),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ack_and_check(input logic [2:0] exp_done, input string tag);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_req_low"}, mem_req, 1'b0);
  endtask

  logic [2:0] exp_g [4];

  initial begin
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    reset   = 1'b1;
    req     = 3'b000;
    we_in   = 3'b010;
    mem_ack = 1'b0;
    addr0   = 32'h100;  addr1  = 32'h200;  addr2  = 32'h300;
    wdata0  = 32'hA0;   wdata1 = 32'hA1;   wdata2 = 32'hA2;
    @(negedge clk);
    @(negedge clk);
    chk("rst_grant", grant, 3'b000);
    chk("rst_sel", sel, 2'b00);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_done", done, 3'b000);
    chk("rst_tmo", timeout_err, 1'b0);
    reset = 1'b0;

    // single request from requester 0
    req = 3'b001;
    @(negedge clk);
    chk("t1_grant", grant, 3'b001);
    chk("t1_sel", sel, 2'b00);
    chk("t1_mem_req", mem_req, 1'b1);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_we", mem_we, 1'b0);
    @(negedge clk);
    ack_and_check(3'b001, "t1");
    chk("t1_grant_clr", grant, 3'b000);
    chk("t1_sel_hold", sel, 2'b00);
    req = 3'b000;
    @(negedge clk);
    chk("t1_done_pulse", done, 3'b000);

    // all three requesting: rotation 0,1,2,0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rr%0d_grant", k), grant, exp_g[k]);
      chk($sformatf("rr%0d_sel", k), sel, k % 3);
      chk($sformatf("rr%0d_addr", k), mem_addr, 32'h100 * ((k % 3) + 1));
      chk($sformatf("rr%0d_wdata", k), mem_wdata, 32'hA0 + (k % 3));
      chk($sformatf("rr%0d_we", k), mem_we, (k % 3) == 1);
      ack_and_check(exp_g[k], $sformatf("rr%0d", k));
      if (k == 3) req = 3'b101;
    end

    // after owner 0, requester 2 must win over 0
    @(negedge clk);
    chk("t3_grant", grant, 3'b100);
    chk("t3_sel", sel, 2'b10);
    chk("t3_addr", mem_addr, 32'h300);
    ack_and_check(3'b100, "t3");
    req = 3'b000;

    // reset in the middle of a requester-1 transaction
    @(negedge clk);
    req = 3'b010;
    @(negedge clk);
    chk("t4_grant", grant, 3'b010);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t4_rst_grant", grant, 3'b000);
    chk("t4_rst_mem_req", mem_req, 1'b0);
    chk("t4_rst_done", done, 3'b000);
    @(negedge clk);
    chk("t4_no_done", done, 3'b000);
    reset = 1'b0;
    req = 3'b111;
    @(negedge clk);
    chk("t4_regrant", grant, 3'b001);
    ack_and_check(3'b001, "t4");
    req = 3'b000;

    // stray ack while idle
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("t5_done", done, 3'b000);
    chk("t5_mem_req", mem_req, 1'b0);
    chk("t5_grant", grant, 3'b000);
    @(negedge clk);
    chk("t5_done2", done, 3'b000);
    req = 3'b100;
    @(negedge clk);
    chk("t5_grant_next", grant, 3'b100);
    ack_and_check(3'b100, "t5");
    req = 3'b000;
    @(negedge clk);

    // requester 1 with no ack
    req = 3'b010;
    @(negedge clk);
    chk("t6_grant", grant, 3'b010);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("t6_wait%0d", i), {done, timeout_err}, {3'b000, 1'b0});
    end
    @(negedge clk);
    chk("t6_tmo", timeout_err, 1'b1);
    chk("t6_done", done, 3'b010);
    chk("t6_mem_req", mem_req, 1'b0);
    chk("t6_grant_clr", grant, 3'b000);
    req = 3'b011;
    @(negedge clk);
    chk("t6_tmo_pulse", timeout_err, 1'b0);
    chk("t6_regrant", grant, 3'b001);
`else
    repeat (20) @(negedge clk);
    chk("t6_still_busy", mem_req, 1'b1);
    chk("t6_grant_hold", grant, 3'b010);
    chk("t6_no_tmo", timeout_err, 1'b0);
    chk("t6_no_done", done, 3'b000);
    ack_and_check(3'b010, "t6");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing one memory port among three requesters (fetch, load, store).
- Drives the 2-bit select of the shared 32-bit 3:1 address and write-data muxes.
- Sequences each transaction: grant, hold the request to memory until ack, then return a done pulse.
- Sits between the pipeline's memory-access stages and the single-ported memory model.

Parameters:
- DATA_WIDTH, 32, width of address and write-data paths.
- MAX_WAIT, 15, cycles in BUSY without mem_ack before abort; used only with the timeout feature.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  3  request per requester, index 0..2; held high until that requester's done.
- we_in  input  3  write enable per requester.
- addr0, addr1, addr2  input  DATA_WIDTH  requester addresses.
- wdata0, wdata1, wdata2  input  DATA_WIDTH  requester write data.
- grant  output  3  one-hot current owner; 0 when IDLE.
- sel  output  2  mux select: 00 = req0, 01 = req1, 10 = req2; 11 never driven.
- mem_req  output  1  request to memory.
- mem_we  output  1  write enable of the granted requester.
- mem_addr  output  DATA_WIDTH  muxed address.
- mem_wdata  output  DATA_WIDTH  muxed write data.
- mem_ack  input  1  memory completion, single-cycle pulse.
- done  output  3  one-hot, one-cycle completion pulse to the owner.
- timeout_err  output  1  one-cycle pulse on abort; tied 0 without the feature.

Behaviour:
- Reset values:
  - state = IDLE; grant = 0, sel = 00, mem_req = 0, done = 0, timeout_err = 0.
  - last-grant pointer = 2, so requester 0 wins first.
- States: IDLE, BUSY.
- IDLE:
  - If req != 0, pick the winner by round-robin order last+1, last+2, last (mod 3).
  - Register grant, sel and mem_req = 1; move to BUSY.
  - Latency: req seen in cycle N gives mem_req, grant and sel valid in cycle N+1.
- BUSY:
  - sel, grant and mem_req are held stable.
  - mem_addr, mem_wdata and mem_we follow the selected requester combinationally.
  - On mem_ack: next cycle done[g] = 1 for one cycle, mem_req = 0, grant = 0, last = g, state = IDLE.
  - sel keeps the last grant's value while IDLE.
- Throughput: at least one IDLE cycle between transactions, so back-to-back grants are 2 cycles apart at best.
- Simultaneous requests: resolved only by round-robin order; no requester is granted twice while another waits.
- req dropped during BUSY: ignored; the transaction completes and done still pulses.
- mem_ack while IDLE: ignored.
- we_in and addr changes during BUSY: the requester is responsible for holding them; the arbiter does not latch them.
- Reset mid-BUSY: immediate return to IDLE with reset values; no done pulse; pointer = 2.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A 4-bit-minimum counter clears on BUSY entry and increments each BUSY cycle without mem_ack.
  - When the count reaches MAX_WAIT: next cycle timeout_err = 1 and done[g] = 1 together, mem_req = 0, last = g, state = IDLE.
  - mem_ack in the same cycle as the limit wins; no error is raised.
- Without the macro: BUSY waits indefinitely; timeout_err is constant 0; no counter logic.

Decomposition:
- Shared package holds:
  - State encoding: IDLE = 1'b0, BUSY = 1'b1.
  - Select codes SEL_REQ0 = 2'b00, SEL_REQ1 = 2'b01, SEL_REQ2 = 2'b10.
  - NUM_REQ = 3 and the MAX_WAIT default.
- Sub-modules: two instances of the existing 32-bit 3:1 mux (address and write data).
- A single-bit 3:1 pick for mem_we is done inline; no other sub-module.

Test Plan:
- Reset, then req = 001, addr0 = 0x100 -> cycle +1: grant = 001, sel = 00, mem_req = 1, mem_addr = 0x100; ack at +3 -> done = 001 at +4, mem_req = 0.
- req = 111 held, ack 2 cycles after each mem_req -> grant order 001, 010, 100, 001; sel sequence 00, 01, 10, 00.
- req = 101 after a grant to 0 -> next grant = 100 (requester 2), not 001.
- Reset asserted while BUSY with grant = 010 -> grant = 0, mem_req = 0, no done pulse; next req = 111 grants 001.
- mem_ack pulsed in IDLE with req = 000 -> no state change, done stays 000.
- ARB_TIMEOUT_EN, MAX_WAIT = 15, req = 010, no ack -> timeout_err = 1 and done = 010 on the same cycle, 16 cycles after mem_req rose; next req = 011 grants 001.
